// File: rtl/xlr8_anapin_seq.sv
// Sequences shared A0..A5 pad use between digital I/O and the ADC: isolate the pad,
// park the I2C pullups for A4/A5, settle, convert once, then restore the pad state.
module xlr8_anapin_seq #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int RES_W          = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conv_req,
  input  logic [2:0]       conv_ch,
  output logic             conv_ack,
  input  logic             i2c_en_cfg,
  input  logic             i2c_busy,
  output logic             i2c_hold,
  output logic             i2c_enable,
  output logic [5:0]       dig_io_oe,
  output logic             adc_start,
  output logic [2:0]       adc_ch,
  input  logic             adc_done,
  input  logic [RES_W-1:0] adc_result,
  output logic [RES_W-1:0] res_data,
  output logic             res_valid,
  output logic             err_timeout,
  output logic             err_badch
);

  typedef enum logic [2:0] {IDLE, WAIT_I2C, ISOLATE, SETTLE, CONVERT, RESTORE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ch_q, ch_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [5:0]       oe_q, oe_d;
  logic             i2c_en_q, i2c_en_d;
  logic             hold_q, hold_d;
  logic             ack_q, ack_d;
  logic             badch_q, badch_d;
  logic             start_q, start_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [5:0]       ch_mask;
  logic             ch_hi;

  for (genvar gi = 0; gi < 6; gi++) begin : g_mask
    assign ch_mask[gi] = (ch_q == 3'(gi));
  end

  // Latched channel is always 0..5, so bit 2 alone marks the I2C-shared pads A4/A5.
  assign ch_hi = ch_q[2];

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    oe_d     = oe_q;
    hold_d   = hold_q;
    ack_d    = 1'b0;
    badch_d  = 1'b0;
    start_d  = 1'b0;
    valid_d  = 1'b0;
    tmo_d    = tmo_q;
    res_d    = res_q;
    i2c_en_d = i2c_en_cfg;
    if (ch_hi && (state_q inside {ISOLATE, SETTLE, CONVERT}))
      i2c_en_d = 1'b0;

    case (state_q)
      IDLE: begin
        // ack_q guard keeps a still-high request from being acked twice in a row
        if (conv_req && !ack_q) begin
          ack_d = 1'b1;
          tmo_d = 1'b0;
          if (conv_ch > 3'd5) begin
            badch_d = 1'b1;
          end else begin
            ch_d = conv_ch;
            if (conv_ch >= 3'd4) begin
              hold_d  = 1'b1;
              state_d = WAIT_I2C;
            end else begin
              state_d = ISOLATE;
            end
          end
        end
      end
      WAIT_I2C: begin
        if (!i2c_busy)
          state_d = ISOLATE;
      end
      ISOLATE: begin
        oe_d    = ~ch_mask;
        cnt_d   = 16'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 16'd0) begin
          start_d = 1'b1;
          cnt_d   = 16'(TIMEOUT_CYCLES - 1);
          state_d = CONVERT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      CONVERT: begin
        if (adc_done) begin
          res_d   = adc_result;
          valid_d = 1'b1;
          state_d = RESTORE;
        end else if (cnt_q == 16'd0) begin
          tmo_d   = 1'b1;
          state_d = RESTORE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RESTORE: begin
        oe_d    = 6'h3F;
        hold_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= 3'd0;
      cnt_q    <= 16'd0;
      oe_q     <= 6'h3F;
      i2c_en_q <= 1'b0;
      hold_q   <= 1'b0;
      ack_q    <= 1'b0;
      badch_q  <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      oe_q     <= oe_d;
      i2c_en_q <= i2c_en_d;
      hold_q   <= hold_d;
      ack_q    <= ack_d;
      badch_q  <= badch_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      res_q    <= res_d;
    end
  end

  assign conv_ack    = ack_q;
  assign err_badch   = badch_q;
  assign i2c_hold    = hold_q;
  assign i2c_enable  = i2c_en_q;
  assign dig_io_oe   = oe_q;
  assign adc_start   = start_q;
  assign adc_ch      = ch_q;
  assign res_data    = res_q;
  assign res_valid   = valid_q;
  assign err_timeout = tmo_q;

endmodule

// File: tb/tb_xlr8_anapin_seq.sv
// Directed bench for xlr8_anapin_seq: inputs driven and outputs sampled on the falling edge.
module tb_xlr8_anapin_seq;

  localparam int RES_W = 10;

  logic             clk = 1'b0;
  logic             rst, conv_req, i2c_en_cfg, i2c_busy, adc_done;
  logic [2:0]       conv_ch;
  logic [RES_W-1:0] adc_result;
  logic             conv_ack, i2c_hold, i2c_enable, adc_start, res_valid, err_timeout, err_badch;
  logic [5:0]       dig_io_oe;
  logic [2:0]       adc_ch;
  logic [RES_W-1:0] res_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_valid  = 0;

  xlr8_anapin_seq #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(1023), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst),
    .conv_req(conv_req), .conv_ch(conv_ch), .conv_ack(conv_ack),
    .i2c_en_cfg(i2c_en_cfg), .i2c_busy(i2c_busy), .i2c_hold(i2c_hold), .i2c_enable(i2c_enable),
    .dig_io_oe(dig_io_oe), .adc_start(adc_start), .adc_ch(adc_ch),
    .adc_done(adc_done), .adc_result(adc_result),
    .res_data(res_data), .res_valid(res_valid),
    .err_timeout(err_timeout), .err_badch(err_badch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (adc_start) n_start++;
    if (res_valid) n_valid++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sel: 0 conv_ack, 1 adc_start, 2 res_valid, 3 err_timeout
  task automatic wait_for(input string tag, input int sel, input int limit, output int cyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < limit) begin
      @(negedge clk);
      cyc++;
      case (sel)
        0:       hit = conv_ack;
        1:       hit = adc_start;
        2:       hit = res_valid;
        default: hit = err_timeout;
      endcase
    end
    chk({tag, "_seen"}, 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, base_s, base_v, bad;
    rst = 1'b1; conv_req = 1'b0; conv_ch = 3'd0; i2c_en_cfg = 1'b1;
    i2c_busy = 1'b0; adc_done = 1'b0; adc_result = '0;

    // Reset state
    tick(1);
    chk("rst_oe",       32'(dig_io_oe),   32'h3F);
    chk("rst_hold",     32'(i2c_hold),    32'd0);
    chk("rst_i2c_en",   32'(i2c_enable),  32'd0);
    chk("rst_res_data", 32'(res_data),    32'd0);
    chk("rst_ack",      32'(conv_ack),    32'd0);
    chk("rst_tmo",      32'(err_timeout), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("idle_i2c_en",  32'(i2c_enable),  32'd1);

    // ch2 conversion
    conv_ch = 3'd2; conv_req = 1'b1;
    wait_for("ch2_ack", 0, 5, cyc);
    conv_req = 1'b0;
    base_v = n_valid;
    wait_for("ch2_start", 1, 40, cyc);
    chk("ch2_start_lat", 32'(cyc),        32'd17);
    chk("ch2_oe",        32'(dig_io_oe),  32'h3B);
    chk("ch2_i2c_en",    32'(i2c_enable), 32'd1);
    chk("ch2_adc_ch",    32'(adc_ch),     32'd2);
    tick(39);
    adc_result = 10'h2A5; adc_done = 1'b1;
    tick(1);
    adc_done = 1'b0; adc_result = '0;
    chk("ch2_valid",     32'(res_valid),  32'd1);
    chk("ch2_res",       32'(res_data),   32'h2A5);
    tick(1);
    chk("ch2_valid_end", 32'(res_valid),  32'd0);
    chk("ch2_valid_cnt", 32'(n_valid - base_v), 32'd1);
    chk("ch2_oe_rest",   32'(dig_io_oe),  32'h3F);

    // ch5 conversion with I2C busy for 30 cycles
    i2c_busy = 1'b1; conv_ch = 3'd5; conv_req = 1'b1;
    wait_for("ch5_ack", 0, 5, cyc);
    conv_req = 1'b0;
    chk("ch5_hold", 32'(i2c_hold), 32'd1);
    bad = 0;
    repeat (29) begin
      tick(1);
      if (dig_io_oe !== 6'h3F || i2c_enable !== 1'b1 || i2c_hold !== 1'b1) bad++;
    end
    chk("ch5_wait_stable", 32'(bad), 32'd0);
    i2c_busy = 1'b0;
    tick(2);
    chk("ch5_oe",     32'(dig_io_oe),  32'h1F);
    chk("ch5_i2c_en", 32'(i2c_enable), 32'd0);
    base_v = n_valid;
    wait_for("ch5_start", 1, 40, cyc);
    chk("ch5_start_lat", 32'(cyc),    32'd16);
    chk("ch5_adc_ch",    32'(adc_ch), 32'd5);
    tick(5);
    adc_result = 10'h155; adc_done = 1'b1;
    tick(1);
    adc_done = 1'b0; adc_result = '0;
    chk("ch5_valid", 32'(res_valid), 32'd1);
    chk("ch5_res",   32'(res_data),  32'h155);
    tick(1);
    chk("ch5_oe_rest",   32'(dig_io_oe),  32'h3F);
    chk("ch5_en_rest",   32'(i2c_enable), 32'd1);
    chk("ch5_hold_rest", 32'(i2c_hold),   32'd0);

    // adc_done while idle is ignored
    base_v = n_valid;
    adc_result = 10'h3FF; adc_done = 1'b1;
    tick(1);
    adc_done = 1'b0; adc_result = '0;
    tick(2);
    chk("idle_done_valid", 32'(n_valid - base_v), 32'd0);
    chk("idle_done_res",   32'(res_data),         32'h155);

    // Timeout on ch1
    conv_ch = 3'd1; conv_req = 1'b1;
    wait_for("to_ack", 0, 5, cyc);
    conv_req = 1'b0;
    base_v = n_valid;
    wait_for("to_start", 1, 40, cyc);
    wait_for("to_flag", 3, 1100, cyc);
    chk("to_latency", 32'(cyc), 32'd1023);
    tick(1);
    chk("to_no_valid", 32'(n_valid - base_v), 32'd0);
    chk("to_oe_rest",  32'(dig_io_oe),   32'h3F);
    chk("to_sticky",   32'(err_timeout), 32'd1);
    conv_ch = 3'd0; conv_req = 1'b1;
    wait_for("to_ack2", 0, 5, cyc);
    conv_req = 1'b0;
    chk("to_cleared", 32'(err_timeout), 32'd0);
    wait_for("ch0_start", 1, 40, cyc);
    chk("ch0_oe", 32'(dig_io_oe), 32'h3E);
    adc_done = 1'b1;
    tick(1);
    adc_done = 1'b0;
    tick(2);

    // Illegal channel
    base_s = n_start;
    conv_ch = 3'd7; conv_req = 1'b1;
    tick(1);
    conv_req = 1'b0;
    chk("bad_ack",   32'(conv_ack),  32'd1);
    chk("bad_flag",  32'(err_badch), 32'd1);
    chk("bad_oe",    32'(dig_io_oe), 32'h3F);
    tick(1);
    chk("bad_pulse", 32'(err_badch), 32'd0);
    tick(20);
    chk("bad_no_start", 32'(n_start - base_s), 32'd0);

    // Reset during SETTLE on ch4
    conv_ch = 3'd4; conv_req = 1'b1;
    wait_for("rs_ack", 0, 5, cyc);
    conv_req = 1'b0;
    base_s = n_start;
    tick(3);
    chk("rs_oe_settle",   32'(dig_io_oe),  32'h2F);
    chk("rs_hold_settle", 32'(i2c_hold),   32'd1);
    chk("rs_en_settle",   32'(i2c_enable), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rs_oe",    32'(dig_io_oe), 32'h3F);
    chk("rs_hold",  32'(i2c_hold),  32'd0);
    chk("rs_start", 32'(adc_start), 32'd0);
    tick(30);
    chk("rs_no_start", 32'(n_start - base_s), 32'd0);
    chk("rs_i2c_en",   32'(i2c_enable),       32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
